// File: rtl/uart_tx.sv
// 8N1-style UART transmitter with a per-frame 16x oversampling tick generator.
// A level-held tx_start must be seen low in IDLE before another frame is accepted.
module uart_tx #(
  parameter int DBIT     = 8,
  parameter int SB_TICK  = 16,
  parameter int BAUD_DIV = 163
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tx_start,
  input  logic [DBIT-1:0] tx_dato_in,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done
);

  localparam int CW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int SMAX = (SB_TICK > 16) ? SB_TICK : 16;
  localparam int SW   = $clog2(SMAX);
  localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [SW-1:0]   s_reg, s_next;
  logic [NW-1:0]   n_reg, n_next;
  logic [DBIT-1:0] shreg_reg, shreg_next;
  logic            tx_reg, tx_next;
  logic            done_reg, done_next;
  logic            armed_reg, armed_next;
  logic            tick;
  logic            accept;

  assign tick   = (cnt_reg == CW'(BAUD_DIV - 1));
  assign accept = (state_reg == IDLE) && tx_start && armed_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      s_reg     <= '0;
      n_reg     <= '0;
      shreg_reg <= '0;
      tx_reg    <= 1'b1;
      done_reg  <= 1'b0;
      armed_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      shreg_reg <= shreg_next;
      tx_reg    <= tx_next;
      done_reg  <= done_next;
      armed_reg <= armed_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    shreg_next = shreg_reg;
    tx_next    = tx_reg;
    done_next  = 1'b0;
    armed_next = armed_reg;
    // Restarting the divider on acceptance aligns every bit to the frame start.
    if (accept || tick) cnt_next = '0;
    else                cnt_next = cnt_reg + CW'(1);

    case (state_reg)
      IDLE: begin
        if (!tx_start) armed_next = 1'b1;
        if (accept) begin
          armed_next = 1'b0;
          shreg_next = tx_dato_in;
          state_next = START;
          tx_next    = 1'b0;
          s_next     = '0;
          n_next     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s_reg == SW'(15)) begin
            state_next = DATA;
            s_next     = '0;
            n_next     = '0;
            tx_next    = shreg_reg[0];
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_reg == SW'(15)) begin
            s_next = '0;
            if (n_reg == NW'(DBIT - 1)) begin
              state_next = STOP;
              tx_next    = 1'b1;
            end else begin
              shreg_next = shreg_reg >> 1;
              tx_next    = shreg_reg[1];
              n_next     = n_reg + NW'(1);
            end
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end
      STOP: begin
        tx_next = 1'b1;
        if (tick) begin
          if (s_reg == SW'(SB_TICK - 1)) begin
            state_next = IDLE;
            s_next     = '0;
            done_next  = 1'b1;
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign tx      = tx_reg;
  assign tx_busy = (state_reg != IDLE);
  assign tx_done = done_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx at BAUD_DIV=4 (64 clk/bit, 640 clk/frame): frame table,
// hand sequences for held start, reset abort and back-to-back, plus a receiver scoreboard.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] din = 8'h00;
  logic       tx, tx_busy, tx_done;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [7:0] sb_q[$];

  typedef struct {
    logic [7:0] din;
    logic [9:0] frame;  // time order: [0]=start, [8:1]=data LSB first, [9]=stop
  } vec_t;

  always #5 clk = ~clk;

  uart_tx #(.DBIT(8), .SB_TICK(16), .BAUD_DIV(4)) dut (
    .clk(clk), .reset(reset), .tx_start(tx_start), .tx_dato_in(din),
    .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  initial begin : done_counter
    forever begin
      @(negedge clk);
      if (tx_done === 1'b1) done_cnt++;
    end
  end

  // Bench receiver: samples at bit centres relative to the first low seen on tx.
  initial begin : rx_mon
    int st;
    int k;
    logic [7:0] b;
    st = 0; k = 0; b = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        st = 0;
      end else if (st == 0) begin
        if (tx === 1'b0) begin
          st = 1;
          k = 0;
        end
      end else begin
        k++;
        if (k == 32) begin
          check("rx_start_bit", tx, 0);
        end else if (k > 32 && k < 608 && (k - 32) % 64 == 0) begin
          b[(k - 32) / 64 - 1] = tx;
        end else if (k == 608) begin
          check("rx_stop_bit", tx, 1);
          if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rx_unexpected_frame: got byte %0h want no frame", b);
          end else begin
            check("rx_byte", b, sb_q.pop_front());
          end
          st = 0;
        end
      end
    end
  end

  // Arms, starts one frame with a one-cycle pulse and checks every cycle of it.
  task automatic run_frame(input logic [7:0] d, input logic [9:0] fr, input string tag,
                           input logic [7:0] mid_din);
    int   err;
    logic got_tx, got_busy, got_done;
    tx_start = 1'b0;
    @(negedge clk);
    check({tag, "_idle_busy"}, tx_busy, 0);
    tx_start = 1'b1;
    din = d;
    sb_q.push_back(d);
    @(negedge clk);
    tx_start = 1'b0;
    for (int bi = 0; bi < 10; bi++) begin
      err = 0;
      got_tx = 1'b0; got_busy = 1'b0; got_done = 1'b0;
      if (bi == 4) din = mid_din;
      for (int c = 0; c < 64; c++) begin
        if (err == 0 && (tx !== fr[bi] || tx_busy !== 1'b1 || tx_done !== 1'b0)) begin
          err = 1;
          got_tx = tx; got_busy = tx_busy; got_done = tx_done;
        end
        @(negedge clk);
      end
      total++;
      if (err != 0) begin
        bad++;
        $display("FAIL %s_bit%0d: got tx=%0b busy=%0b done=%0b want tx=%0b busy=1 done=0",
                 tag, bi, got_tx, got_busy, got_done, fr[bi]);
      end
    end
    check({tag, "_done_pulse"}, tx_done, 1);
    check({tag, "_busy_end"}, tx_busy, 0);
    @(negedge clk);
    check({tag, "_done_clear"}, tx_done, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t vecs[8];
    int   d0;
    int   c;
    int   seen_busy;

    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h3C, {1'b1, 8'h3C, 1'b0}};
    vecs[2] = '{8'h00, 10'b1000000000};
    vecs[3] = '{8'hFF, 10'b1111111110};
    vecs[4] = '{8'h55, {1'b1, 8'h55, 1'b0}};
    vecs[5] = '{8'hAA, {1'b1, 8'hAA, 1'b0}};
    vecs[6] = '{8'h01, 10'b1000000010};
    vecs[7] = '{8'h80, 10'b1100000000};

    // Reset, then tx_start already high at release: not armed, no frame.
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    tx_start = 1'b1;
    reset = 1'b0;
    seen_busy = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_busy !== 1'b0 || tx !== 1'b1) seen_busy = 1;
    end
    check("unarmed_no_frame", seen_busy, 0);
    tx_start = 1'b0;

    foreach (vecs[i]) begin
      run_frame(vecs[i].din, vecs[i].frame, $sformatf("vec%0d", i), vecs[i].din);
      $display("frame %0d: byte %0h sent", i, vecs[i].din);
    end

    // Debug-unit style: hold tx_start until tx_done, then drop it.
    tx_start = 1'b0;
    @(negedge clk);
    d0 = done_cnt;
    tx_start = 1'b1;
    din = 8'h3C;
    sb_q.push_back(8'h3C);
    @(negedge clk);
    c = 0;
    while (tx_done !== 1'b1 && c < 800) begin
      @(negedge clk);
      c++;
    end
    check("held_done_latency", c, 640);
    tx_start = 1'b0;
    repeat (700) @(negedge clk);
    check("held_one_frame", done_cnt - d0, 1);
    check("held_busy_after", tx_busy, 0);
    $display("held start: 0x3C frame, latency %0d", c);

    // tx_start held 2000 cycles: exactly one frame.
    tx_start = 1'b0;
    @(negedge clk);
    d0 = done_cnt;
    tx_start = 1'b1;
    din = 8'h00;
    sb_q.push_back(8'h00);
    repeat (2000) @(negedge clk);
    check("long_hold_frames", done_cnt - d0, 1);
    check("long_hold_tx", tx, 1);
    check("long_hold_busy", tx_busy, 0);
    tx_start = 1'b0;
    $display("long hold: %0d frames", done_cnt - d0);

    // Reset in the middle of DATA abandons the frame.
    @(negedge clk);
    tx_start = 1'b1;
    din = 8'hF0;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (199) @(negedge clk);
    check("abort_pre_tx", tx, 0);
    reset = 1'b1;
    @(negedge clk);
    check("abort_tx", tx, 1);
    check("abort_busy", tx_busy, 0);
    @(negedge clk);
    reset = 1'b0;
    d0 = done_cnt;
    repeat (800) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_idle_tx", tx, 1);
    $display("reset abort: frame dropped");
    run_frame(8'hFF, 10'b1111111110, "post_abort", 8'hFF);

    // Back-to-back with a mid-frame tx_dato_in change on the first frame.
    run_frame(8'h55, {1'b1, 8'h55, 1'b0}, "b2b_first", 8'h0F);
    tx_start = 1'b1;
    din = 8'hAA;
    sb_q.push_back(8'hAA);
    check("b2b_gap_tx", tx, 1);
    @(negedge clk);
    check("b2b_start_tx", tx, 0);
    check("b2b_start_busy", tx_busy, 1);
    tx_start = 1'b0;
    c = 0;
    while (tx_done !== 1'b1 && c < 700) begin
      if (c == 300) din = 8'h33;
      @(negedge clk);
      c++;
    end
    check("b2b_second_latency", c, 640);
    repeat (20) @(negedge clk);
    $display("back-to-back: 0x55 then 0xAA");

    check("scoreboard_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
